// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bundle for the hazard and stall sequencer
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] IFID_rs;
    logic [REG_W-1:0] IFID_rt;
    logic             IFID_useRt;
    logic             IFID_isMDU;
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_rt;
    logic             Branch_taken;
    logic             Jump;
    logic             MDU_start;
    logic             PCWr;
    logic             IFIDWr;
    logic             rstIFID;
    logic             IDEX_bubble;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output IFID_rs, IFID_rt, IFID_useRt, IFID_isMDU,
        output IDEX_MemRead, IDEX_rt, Branch_taken, Jump, MDU_start,
        input  PCWr, IFIDWr, rstIFID, IDEX_bubble, mdu_busy, stall_cnt
    );

    modport slave (
        input  IFID_rs, IFID_rt, IFID_useRt, IFID_isMDU,
        input  IDEX_MemRead, IDEX_rt, Branch_taken, Jump, MDU_start,
        output PCWr, IFIDWr, rstIFID, IDEX_bubble, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch flush / MDU-busy stall sequencer
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_mh;
    logic w_stall;
    logic w_flush;
    logic w_pcwr;
    logic w_ifidwr;
    logic w_rstifid;
    logic w_bubble;

    assign w_lu = bus.IDEX_MemRead && (bus.IDEX_rt != '0) &&
                  ((bus.IDEX_rt == bus.IFID_rs) ||
                   (bus.IFID_useRt && (bus.IDEX_rt == bus.IFID_rt)));
    assign w_mh    = (r_state == BUSY) && bus.IFID_isMDU;
    assign w_stall = w_lu || w_mh;
    assign w_flush = bus.Branch_taken || bus.Jump;

    // Stall wins over flush: ID operands cannot be trusted while stalled.
    always_comb begin
        w_pcwr    = 1'b1;
        w_ifidwr  = 1'b1;
        w_rstifid = 1'b0;
        w_bubble  = 1'b0;
        if (rst) begin
            w_pcwr    = 1'b0;
            w_ifidwr  = 1'b0;
            w_rstifid = 1'b1;
            w_bubble  = 1'b1;
        end else if (w_stall) begin
            w_pcwr    = 1'b0;
            w_ifidwr  = 1'b0;
            w_bubble  = 1'b1;
        end else if (w_flush) begin
            w_rstifid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (bus.MDU_start) begin
                r_state <= BUSY;
                r_cnt   <= CW'(MDU_LAT - 1);
            end
        end else begin
            // MDU_start while BUSY is deliberately ignored.
            if (r_cnt == '0) begin
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pcwr && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.PCWr        = w_pcwr;
    assign bus.IFIDWr      = w_ifidwr;
    assign bus.rstIFID     = w_rstifid;
    assign bus.IDEX_bubble = w_bubble;
    assign bus.mdu_busy    = (r_state == BUSY);
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 3;
    localparam int SC_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic pcwr;
        logic ifidwr;
        logic rstifid;
        logic bubble;
        logic busy;
        logic [CNT_W-1:0] sc;
        bit   chk_state;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    // reference state: remaining busy cycles and stall count as plain integers
    int   m_rem = 0;
    int   m_sc = 0;
    bit   m_known = 0;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) dif ();

    hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic step(input bit r, input int rs, input int rt, input bit use_rt,
                        input bit is_mdu, input bit mem_rd, input int ex_rt,
                        input bit br, input bit jmp, input bit start);
        exp_t e;
        bit   lu;
        bit   mh;
        @(posedge clk);
        #1;
        rst              = r;
        dif.IFID_rs      = REG_W'(rs);
        dif.IFID_rt      = REG_W'(rt);
        dif.IFID_useRt   = use_rt;
        dif.IFID_isMDU   = is_mdu;
        dif.IDEX_MemRead = mem_rd;
        dif.IDEX_rt      = REG_W'(ex_rt);
        dif.Branch_taken = br;
        dif.Jump         = jmp;
        dif.MDU_start    = start;
        lu = mem_rd && ex_rt != 0 && (ex_rt == rs || (use_rt && ex_rt == rt));
        mh = (m_rem > 0) && is_mdu;
        if (r)              e = '{0, 0, 1, 1, 0, 0, 0};
        else if (lu || mh)  e = '{0, 0, 0, 1, 0, 0, 0};
        else if (br || jmp) e = '{1, 1, 1, 0, 0, 0, 0};
        else                e = '{1, 1, 0, 0, 0, 0, 0};
        e.busy      = (m_rem > 0);
        e.sc        = CNT_W'(m_sc);
        e.chk_state = m_known;
        sb.push_back(e);
        if (r) begin
            m_rem = 0;
            m_sc = 0;
            m_known = 1;
        end else begin
            if (m_rem > 0)  m_rem--;
            else if (start) m_rem = MDU_LAT;
            if (!e.pcwr && m_sc < SC_MAX) m_sc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("PCWr", int'(dif.PCWr), int'(e.pcwr));
            chk("IFIDWr", int'(dif.IFIDWr), int'(e.ifidwr));
            chk("rstIFID", int'(dif.rstIFID), int'(e.rstifid));
            chk("IDEX_bubble", int'(dif.IDEX_bubble), int'(e.bubble));
            if (e.chk_state) begin
                chk("mdu_busy", int'(dif.mdu_busy), int'(e.busy));
                chk("stall_cnt", int'(dif.stall_cnt), int'(e.sc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0)
            assert (!(dif.MDU_start && dif.mdu_busy))
            else $error("MDU_start issued while MDU busy");
    end

    initial begin
        rst = 1'b1;
        dif.IFID_rs = '0; dif.IFID_rt = '0; dif.IFID_useRt = 0; dif.IFID_isMDU = 0;
        dif.IDEX_MemRead = 0; dif.IDEX_rt = '0; dif.Branch_taken = 0; dif.Jump = 0;
        dif.MDU_start = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs, then the x0 exemption, then rt-only match
        step(0, 8, 3, 0, 0, 1, 8, 0, 0, 0);
        step(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        step(0, 4, 9, 1, 0, 1, 9, 0, 0, 0);
        step(0, 4, 9, 0, 0, 1, 9, 0, 0, 0);
        // branch flush alone, then branch colliding with load-use
        step(0, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        step(0, 8, 2, 0, 0, 1, 8, 1, 0, 0);
        idle(1);
        // MDU window with a dependent instruction held in ID
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 2, 0, 1, 0, 0, 0, 0, 0);
        // jump inside the window with no MDU dependency
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 2, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        // reset two cycles into the window
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // saturation of stall_cnt
        for (int i = 0; i < 10; i++) step(0, 5, 2, 0, 0, 1, 5, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 63) == 0);
            step(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 (m_rem == 0) && ($urandom_range(0, 5) == 0));
        end
        idle(1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
